// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state, opcode and flag-index definitions for the ALU operand sequencer
package alu_seq_pkg;
  typedef enum logic [1:0] {WAIT_A, WAIT_B, WAIT_OP, SHOW} state_t;
  localparam logic [1:0] OP_SUB = 2'd0;
  localparam logic [1:0] OP_ADD = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;
  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_P = 0;
endpackage

// File: rtl/alu_operand_sequencer_edge_pulse.sv
// edge_pulse: one-cycle pulse on a rising edge; history resets high so a held input stays silent
module edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic p
);
  logic d_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) d_q <= 1'b1;
    else d_q <= d;
  assign p = d & ~d_q;
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads A, B and OpCode from one switch bus and captures the ALU result
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int M = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [M-1:0] data_in,
  input  logic         enter,
  input  logic         undo,
  output logic [M-1:0] alu_a,
  output logic [M-1:0] alu_b,
  output logic [1:0]   alu_opcode,
  input  logic [M-1:0] alu_result,
  input  logic [4:0]   alu_flags,
  output logic         result_valid,
  output logic [M-1:0] result_q,
  output logic [4:0]   flags_q,
  output logic [M-1:0] display_value,
  output logic [3:0]   state_leds
);
  state_t state, state_n;
  logic enter_p, undo_p, go;
  edge_pulse u_enter (.clk(clk), .rst_n(rst_n), .d(enter), .p(enter_p));
  edge_pulse u_undo  (.clk(clk), .rst_n(rst_n), .d(undo),  .p(undo_p));
  // undo wins a same-cycle collision, so enter only acts alone
  assign go = enter_p & ~undo_p;
  always_comb begin
    state_n = state;
    if (undo_p)
      state_n = state == WAIT_B  ? WAIT_A  :
                state == WAIT_OP ? WAIT_B  :
                state == SHOW    ? WAIT_OP : state;
    else if (go)
      state_n = state == WAIT_A  ? WAIT_B  :
                state == WAIT_B  ? WAIT_OP :
                state == WAIT_OP ? SHOW    : WAIT_A;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state        <= WAIT_A;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      result_q     <= '0;
      flags_q      <= '0;
      result_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (go && state == WAIT_A) alu_a <= data_in;
      if (go && state == WAIT_B) alu_b <= data_in;
      if (go && state == WAIT_OP) alu_opcode <= data_in[1:0];
      if (state == SHOW) begin
        result_q <= alu_result;
        flags_q  <= alu_flags;
      end
      result_valid <= state == SHOW && !undo_p;
    end
  assign display_value = (state == SHOW && result_valid) ? result_q : data_in;
  assign state_leds    = 4'b0001 << state;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: scoreboard bench with a behavioural ALU attached to the sequencer
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0, enter = 1'b0, undo = 1'b0;
  logic [7:0] data_in = '0, alu_a, alu_b, alu_res, result_q, display_value;
  logic [1:0] alu_op, last_op;
  logic [4:0] alu_flg, flags_q;
  logic [3:0] state_leds;
  logic result_valid;
  logic [12:0] sb[$];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.M(8)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .enter(enter), .undo(undo),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_op), .alu_result(alu_res),
    .alu_flags(alu_flg), .result_valid(result_valid), .result_q(result_q),
    .flags_q(flags_q), .display_value(display_value), .state_leds(state_leds)
  );

  function automatic logic [12:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    logic [8:0] s;
    logic [4:0] f;
    s = op == OP_SUB ? {1'b0, a} - {1'b0, b} :
        op == OP_ADD ? {1'b0, a} + {1'b0, b} :
        op == OP_OR  ? {1'b0, a | b} : {1'b0, a & b};
    f[FLAG_N] = s[7];
    f[FLAG_Z] = s[7:0] == 8'h00;
    f[FLAG_C] = s[8];
    f[FLAG_V] = op == OP_SUB ? (a[7] != b[7] && s[7] != a[7]) :
                op == OP_ADD ? (a[7] == b[7] && s[7] != a[7]) : 1'b0;
    f[FLAG_P] = ^s[7:0];
    return {f, s[7:0]};
  endfunction

  always_comb {alu_flg, alu_res} = alu_model(alu_a, alu_b, alu_op);

  task automatic press(input logic [7:0] v);
    data_in = v;
    enter = 1'b1;
    @(posedge clk); #1;
    enter = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic press_undo();
    undo = 1'b1;
    @(posedge clk); #1;
    undo = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic finish_op();
    logic [12:0] e;
    for (int i = 0; i < 8 && !result_valid; i++) begin @(posedge clk); #1; end
    checks++;
    if (!result_valid) begin
      errors++;
      $display("FAIL result_valid_timeout got %b want 1", result_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got result %h want a queued entry", result_q);
    end else begin
      e = sb.pop_front();
      if ({flags_q, result_q} !== e) begin
        errors++;
        $display("FAIL capture got flags %b result %h want flags %b result %h", flags_q, result_q, e[12:8], e[7:0]);
      end
      checks++;
      if (display_value !== e[7:0]) begin
        errors++;
        $display("FAIL display_show got %h want %h", display_value, e[7:0]);
      end
    end
  endtask

  task automatic enter_opcode(input logic [1:0] op);
    data_in = {6'h2A, op};
    enter = 1'b1;
    @(posedge clk); #1;
    enter = 1'b0;
    last_op = op;
    checks++;
    if (state_leds !== 4'b1000 || result_valid !== 1'b0 || alu_op !== op) begin
      errors++;
      $display("FAIL show_entry got leds %b valid %b op %0d want 1000 0 %0d", state_leds, result_valid, alu_op, op);
    end
    finish_op();
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    press(a);
    press(b);
    checks++;
    if (alu_a !== a || alu_b !== b || state_leds !== 4'b0100) begin
      errors++;
      $display("FAIL operands got a %h b %h leds %b want %h %h 0100", alu_a, alu_b, state_leds, a, b);
    end
    sb.push_back(alu_model(a, b, op));
    enter_opcode(op);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_in = 8'h00;
    #3;
    checks++;
    if ({alu_a, alu_b, alu_op, result_q, flags_q, result_valid} !== '0 || state_leds !== 4'b0001) begin
      errors++;
      $display("FAIL reset got a %h b %h op %0d r %h f %b v %b leds %b want zeros 0001", alu_a, alu_b, alu_op, result_q, flags_q, result_valid, state_leds);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    data_in = 8'h5A;
    #1;
    checks++;
    if (display_value !== 8'h5A) begin
      errors++;
      $display("FAIL preview got %h want 5a", display_value);
    end
  endtask

  task automatic test_sub();
    run_op(8'h05, 8'h03, OP_SUB);
    checks++;
    if (result_q !== 8'h02 || flags_q !== 5'b00001) begin
      errors++;
      $display("FAIL sub_const got %h %b want 02 00001", result_q, flags_q);
    end
    press(8'h00);
  endtask

  task automatic test_add_overflow();
    run_op(8'h7F, 8'h01, OP_ADD);
    checks++;
    if (result_q !== 8'h80 || flags_q !== 5'b10011 || display_value !== 8'h80) begin
      errors++;
      $display("FAIL add_const got %h %b disp %h want 80 10011 80", result_q, flags_q, display_value);
    end
    press(8'h00);
    checks++;
    if (state_leds !== 4'b0001 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL new_op got leds %b valid %b want 0001 0", state_leds, result_valid);
    end
  endtask

  task automatic test_undo();
    press(8'h10);
    press_undo();
    checks++;
    if (state_leds !== 4'b0001 || alu_a !== 8'h10) begin
      errors++;
      $display("FAIL undo_b got leds %b a %h want 0001 10", state_leds, alu_a);
    end
    press(8'h20);
    checks++;
    if (state_leds !== 4'b0010 || alu_a !== 8'h20) begin
      errors++;
      $display("FAIL reload_a got leds %b a %h want 0010 20", state_leds, alu_a);
    end
  endtask

  task automatic test_simultaneous();
    press(8'h33);
    data_in = 8'h03;
    enter = 1'b1;
    undo = 1'b1;
    @(posedge clk); #1;
    enter = 1'b0;
    undo = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (state_leds !== 4'b0010 || alu_op !== last_op) begin
      errors++;
      $display("FAIL both_pressed got leds %b op %0d want 0010 %0d", state_leds, alu_op, last_op);
    end
    press_undo();
  endtask

  task automatic test_held();
    logic [3:0] prev;
    int moves;
    moves = 0;
    data_in = 8'h44;
    enter = 1'b1;
    prev = state_leds;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (state_leds !== prev) moves++;
      prev = state_leds;
    end
    enter = 1'b0;
    checks++;
    if (moves != 1 || state_leds !== 4'b0010 || alu_a !== 8'h44) begin
      errors++;
      $display("FAIL held_enter got moves %0d leds %b a %h want 1 0010 44", moves, state_leds, alu_a);
    end
    @(posedge clk); #1;
    press_undo();
  endtask

  task automatic test_show_undo();
    run_op(8'h0F, 8'hF0, OP_OR);
    data_in = 8'h6C;
    press_undo();
    checks++;
    if (state_leds !== 4'b0100 || result_valid !== 1'b0 || display_value !== 8'h6C) begin
      errors++;
      $display("FAIL show_undo got leds %b valid %b disp %h want 0100 0 6c", state_leds, result_valid, display_value);
    end
    sb.push_back(alu_model(8'h0F, 8'hF0, OP_AND));
    enter_opcode(OP_AND);
    checks++;
    if (flags_q !== 5'b01000 || result_q !== 8'h00) begin
      errors++;
      $display("FAIL and_zero got %h %b want 00 01000", result_q, flags_q);
    end
    press(8'h00);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom), 8'($urandom), 2'(i % 4));
      press(8'h00);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d entries want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    run_op(8'h81, 8'h02, OP_SUB);
    data_in = 8'h00;
    enter = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({alu_a, alu_b, alu_op, result_q, flags_q, result_valid, display_value} !== '0 || state_leds !== 4'b0001) begin
      errors++;
      $display("FAIL async_reset got a %h b %h op %0d r %h f %b v %b leds %b want zeros 0001", alu_a, alu_b, alu_op, result_q, flags_q, result_valid, state_leds);
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    checks++;
    if (state_leds !== 4'b0001) begin
      errors++;
      $display("FAIL held_through_reset got leds %b want 0001", state_leds);
    end
    enter = 1'b0;
    @(posedge clk); #1;
    press(8'h11);
    checks++;
    if (state_leds !== 4'b0010 || alu_a !== 8'h11) begin
      errors++;
      $display("FAIL after_reset got leds %b a %h want 0010 11", state_leds, alu_a);
    end
  endtask

  initial begin
    last_op = OP_SUB;
    test_reset();
    test_sub();
    test_add_overflow();
    test_undo();
    test_simultaneous();
    test_held();
    test_show_undo();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Sequential front end that feeds the combinational M-bit ALU (inputs A, B, OpCode; outputs Result, Flags = {N,Z,C,V,P}).
- A single shared data_in bus (board switches) is loaded step by step, driven by debounced enter/undo buttons: operand A, then operand B, then OpCode.
- Holds the registered ALU inputs, captures the ALU Result/Flags once the operation is complete, and drives display value and state LEDs.

Parameters:
M, 8, operand/result width; must match the ALU's M.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
data_in  in  M  switch bus; OpCode uses data_in[1:0] only
enter  in  1  debounced level button, synchronous to clk; advance step
undo  in  1  debounced level button, synchronous to clk; go back one step
alu_a  out  M  registered operand A to ALU
alu_b  out  M  registered operand B to ALU
alu_opcode  out  2  registered OpCode to ALU (0 sub, 1 add, 2 or, 3 and)
alu_result  in  M  ALU Result
alu_flags  in  5  ALU Flags {N,Z,C,V,P}
result_valid  out  1  captured result/flags valid
result_q  out  M  captured result
flags_q  out  5  captured flags
display_value  out  M  value for the display driver
state_leds  out  4  one-hot state {SHOW,WAIT_OP,WAIT_B,WAIT_A}

Behaviour:
- Reset: all registers cleared asynchronously when rst_n=0; state=WAIT_A. alu_a=alu_b=0, alu_opcode=0, result_q=0, flags_q=0, result_valid=0, state_leds=4'b0001. Edge-detector history registers reset to 1, so a button held through reset produces no pulse until it is released and pressed again. Reset mid-sequence discards the partial operation.
- Edge detection: enter_p = enter & ~enter_d and undo_p = undo & ~undo_d, where enter_d and undo_d are the previous-cycle samples. A held button gives exactly one pulse.
- FSM, 4 states; undo_p has priority over enter_p when both are present in the same cycle:
  - WAIT_A: enter_p loads alu_a<=data_in, next state WAIT_B. undo_p is ignored.
  - WAIT_B: enter_p loads alu_b<=data_in, next state WAIT_OP. undo_p returns to WAIT_A.
  - WAIT_OP: enter_p loads alu_opcode<=data_in[1:0], next state SHOW. undo_p returns to WAIT_B.
  - SHOW: enter_p returns to WAIT_A (start a new operation). undo_p returns to WAIT_OP and clears result_valid.
- Undo never clears the operand registers. The old value stays on the ALU inputs until it is overwritten by the next enter.
- Capture: while state==SHOW, result_q<=alu_result and flags_q<=alu_flags every cycle, and result_valid<=1. In any other state, result_q and flags_q hold their value and result_valid<=0.
- Latency: enter_p sampled at edge n loads the opcode and sets state=SHOW at edge n. The first capture is at edge n+1, so result_valid is high from edge n+1 onward.
- display_value (combinational): result_q when state==SHOW && result_valid; otherwise data_in, giving live switch preview while loading.
- state_leds (combinational): decoded from state.
- Width rules: no arithmetic in this block. data_in[M-1:2] is ignored in WAIT_OP.

Decomposition:
- Package alu_seq_pkg:
  - state_t enum (WAIT_A, WAIT_B, WAIT_OP, SHOW)
  - opcode constants OP_SUB=2'd0, OP_ADD=2'd1, OP_OR=2'd2, OP_AND=2'd3
  - flag index constants FLAG_N=4, FLAG_Z=3, FLAG_C=2, FLAG_V=1, FLAG_P=0
- Sub-module edge_pulse: rising-edge one-cycle pulse generator with async active-low reset and history reset value 1. Instantiated twice (enter, undo).
- The top level contains the FSM, the registers and the output decode. The ALU itself is instantiated outside, in the top-level integration.

Test Plan:
- M=8, ALU attached. Enter 0x05, enter 0x03, enter opcode 0 -> result_q=0x02, flags_q=5'b00001, result_valid high one cycle after entering SHOW.
- Operands 0x7F, 0x01, opcode 1 -> result_q=0x80, flags_q=5'b10011 (N, V, P set); display_value=0x80.
- In WAIT_A enter 0x10, then undo -> state WAIT_A, alu_a still 0x10. Enter 0x20 -> alu_a=0x20, state WAIT_B.
- enter and undo rise on the same cycle in WAIT_OP -> state WAIT_B, alu_opcode unchanged.
- enter held high for 50 cycles in WAIT_A -> exactly one transition, to WAIT_B.
- rst_n pulsed low while in SHOW -> all outputs 0 immediately (asynchronous), state_leds=4'b0001. enter held across reset release -> no transition until it is released and pressed again.
